dac_spi_tx: RTL and testbench



---
 rtl/dac_spi_tx.sv | 207 ++++++++++++++++++++
 tb/tb_dac_spi_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serial DAC output stage.
// Takes one 8-bit sample per valid/ready handshake and shifts it out as a
// 16-bit SPI mode-0 frame {CTRL, sample, 4'b0000}, MSB first. A frame is
// followed by a chip-select-high gap before the next sample is accepted.
// All outputs come straight from flops.

module dac_spi_tx #(
  parameter int unsigned CLK_DIV = 4,        // clk cycles per sclk half-period
  parameter int unsigned CS_HIGH = 2,        // clk cycles of cs_n high after a frame
  parameter logic [3:0]  CTRL    = 4'b0011   // DAC control nibble at frame head
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  output logic       busy,
  output logic       frame_done
);

  // Counter widths: the extra bit keeps the CLK_DIV=1 / CS_HIGH=1 cases
  // at a legal one-bit width.
  localparam int unsigned HW = $clog2(CLK_DIV) + 1;
  localparam int unsigned GW = $clog2(CS_HIGH) + 1;

  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(CS_HIGH - 1);
  localparam logic [3:0]    BIT_FIRST = 4'd15;
  localparam logic [3:0]    BIT_LAST  = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Assemble the on-wire frame for one sample.
  function automatic logic [15:0] build_frame(input logic [7:0] sample);
    return {CTRL, sample, 4'b0000};
  endfunction

  // FSM and datapath state
  state_e        state_q, state_d;
  logic [HW-1:0] half_q, half_d;     // cycle within the current sclk half-period
  logic          phase_q, phase_d;   // 0 = low half, 1 = high half of a bit period
  logic [3:0]    bit_q, bit_d;       // index of the bit currently on mosi
  logic [GW-1:0] gap_q, gap_d;       // cycle within the cs_n-high gap
  logic [15:0]   shreg_q, shreg_d;   // frame shift register, MSB drives mosi

  // Registered outputs
  logic din_ready_q, din_ready_d;
  logic busy_q, busy_d;
  logic sclk_q, sclk_d;
  logic mosi_q, mosi_d;
  logic cs_n_q, cs_n_d;
  logic frame_done_q, frame_done_d;

  // Decoded events
  logic accept_s;
  logic half_end_s;
  logic last_bit_s;
  logic gap_end_s;

  assign accept_s   = (state_q == ST_IDLE) && din_ready_q && din_valid;
  assign half_end_s = (half_q == HALF_LAST);
  assign last_bit_s = (bit_q == BIT_LAST);
  assign gap_end_s  = (gap_q == GAP_LAST);

  // State and output registers; asynchronous reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      half_q       <= '0;
      phase_q      <= 1'b0;
      bit_q        <= 4'd0;
      gap_q        <= '0;
      shreg_q      <= 16'h0000;
      din_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      half_q       <= half_d;
      phase_q      <= phase_d;
      bit_q        <= bit_d;
      gap_q        <= gap_d;
      shreg_q      <= shreg_d;
      din_ready_q  <= din_ready_d;
      busy_q       <= busy_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
      cs_n_q       <= cs_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic: handshake, half-period / bit stepping, and gap timing.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    shreg_d = shreg_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          // Sample is captured here; din is ignored for the rest of the frame.
          state_d = ST_SHIFT;
          half_d  = '0;
          phase_d = 1'b0;
          bit_d   = BIT_FIRST;
          shreg_d = build_frame(din);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!half_end_s) begin
          half_d = half_q + HW'(1);
        end else if (!phase_q) begin
          // Low half done: raise sclk for the DAC to sample the stable bit.
          half_d  = '0;
          phase_d = 1'b1;
        end else if (!last_bit_s) begin
          // High half done: drop sclk and present the next bit together.
          half_d  = '0;
          phase_d = 1'b0;
          bit_d   = bit_q - 4'd1;
          shreg_d = {shreg_q[14:0], 1'b0};
        end else begin
          // High half of the final bit done: release the DAC.
          state_d = ST_GAP;
          half_d  = '0;
          phase_d = 1'b0;
          gap_d   = '0;
          shreg_d = 16'h0000;
        end
      end
      ST_GAP: begin
        if (gap_end_s) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        half_d  = '0;
        phase_d = 1'b0;
        bit_d   = 4'd0;
        gap_d   = '0;
        shreg_d = 16'h0000;
      end
    endcase
  end

  // Output decode from the upcoming state so every pin is a flop output.
  always_comb begin
    din_ready_d  = 1'b0;
    busy_d       = 1'b0;
    sclk_d       = 1'b0;
    mosi_d       = 1'b0;
    cs_n_d       = 1'b1;
    frame_done_d = 1'b0;
    case (state_d)
      ST_IDLE: begin
        din_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
      ST_SHIFT: begin
        busy_d = 1'b1;
        cs_n_d = 1'b0;
        sclk_d = phase_d;
        mosi_d = shreg_d[15];
      end
      ST_GAP: begin
        busy_d = 1'b1;
        // Pulse only on the SHIFT->GAP transition, i.e. as cs_n rises.
        if (state_q == ST_SHIFT) begin
          frame_done_d = 1'b1;
        end else begin
          frame_done_d = 1'b0;
        end
      end
      default: begin
        din_ready_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  assign din_ready  = din_ready_q;
  assign busy       = busy_q;
  assign sclk       = sclk_q;
  assign mosi       = mosi_q;
  assign cs_n       = cs_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: one instance with default parameters, one with
// CLK_DIV=1 / CS_HIGH=1. A cycle-accurate observer reconstructs each frame
// from the SPI pins and compares it with the frame rule and the timing
// expected from the accept edge (cycle n = value between edges n-1 and n).

module tb_dac_spi_tx;

  localparam int DA = 4;  // CLK_DIV of instance a
  localparam int CA = 2;  // CS_HIGH of instance a
  localparam int DC = 1;  // CLK_DIV of instance c
  localparam int CC = 1;  // CS_HIGH of instance c

  logic clk = 1'b0;
  logic rst;
  logic [7:0] din_a, din_c;
  logic valid_a, valid_c;
  logic rdy_a, sclk_a, mosi_a, csn_a, busy_a, fd_a;
  logic rdy_c, sclk_c, mosi_c, csn_c, busy_c, fd_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dac_spi_tx #(.CLK_DIV(DA), .CS_HIGH(CA), .CTRL(4'b0011)) u_dut_a (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(valid_a), .din_ready(rdy_a),
    .sclk(sclk_a), .mosi(mosi_a), .cs_n(csn_a), .busy(busy_a), .frame_done(fd_a)
  );

  dac_spi_tx #(.CLK_DIV(DC), .CS_HIGH(CC), .CTRL(4'b0011)) u_dut_c (
    .clk(clk), .rst(rst), .din(din_c), .din_valid(valid_c), .din_ready(rdy_c),
    .sclk(sclk_c), .mosi(mosi_c), .cs_n(csn_c), .busy(busy_c), .frame_done(fd_c)
  );

  typedef struct {
    logic [15:0] word;
    int rises;
    int rise_bad;
    int cs_first;
    int cs_last;
    int cs_low;
    int fd_cycle;
    int fd_cnt;
    int rdy_cycle;
    int mosi_bad;
    int busy_bad;
    int idle_bad;
  } mon_t;

  typedef struct {
    logic [7:0]  din;
    logic [7:0]  after;
    logic [15:0] exp_word;
  } vec_t;

  // Reference frame: control nibble, sample, four zero pad bits.
  function automatic logic [15:0] model_word(input logic [7:0] d);
    logic [15:0] w;
    w = 16'(4'b0011) * 16'd4096 + 16'(d) * 16'd16;
    return w;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic [7:0] d, input logic v);
    if (sel) begin
      din_c = d; valid_c = v;
    end else begin
      din_a = d; valid_a = v;
    end
  endtask

  // Wait (bounded) for din_ready, then present a sample; the next rising edge accepts.
  task automatic launch(input bit sel, input logic [7:0] d, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (((sel ? rdy_c : rdy_a) !== 1'b1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".ready_wait"}, (n < 400) ? 1 : 0, 1);
    drive(sel, d, 1'b1);
  endtask

  // Observe one frame starting at cycle 1 after the accept edge, until din_ready returns.
  task automatic monitor(input bit sel, input int D, input logic [7:0] after,
                         input logic keep_v, output mon_t m);
    logic s_sclk, s_mosi, s_csn, s_fd, s_rdy, s_busy;
    logic p_sclk, p_mosi;
    m.word = 16'h0000; m.rises = 0; m.rise_bad = 0;
    m.cs_first = -1; m.cs_last = -1; m.cs_low = 0;
    m.fd_cycle = -1; m.fd_cnt = 0; m.rdy_cycle = -1;
    m.mosi_bad = 0; m.busy_bad = 0; m.idle_bad = 0;
    p_sclk = 1'b0; p_mosi = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (c == 1) drive(sel, after, keep_v);
      s_sclk = sel ? sclk_c : sclk_a;
      s_mosi = sel ? mosi_c : mosi_a;
      s_csn  = sel ? csn_c  : csn_a;
      s_fd   = sel ? fd_c   : fd_a;
      s_rdy  = sel ? rdy_c  : rdy_a;
      s_busy = sel ? busy_c : busy_a;
      if (s_csn === 1'b0) begin
        m.cs_low++;
        if (m.cs_first < 0) m.cs_first = c;
        m.cs_last = c;
        if (c > 1 && ((c - 1) % (2 * D)) != 0 && s_mosi !== p_mosi) m.mosi_bad++;
      end else if (s_sclk !== 1'b0 || s_mosi !== 1'b0) begin
        m.idle_bad++;
      end
      if (s_sclk === 1'b1 && p_sclk === 1'b0) begin
        m.rises++;
        m.word = {m.word[14:0], s_mosi};
        if (c != 1 + D + 2 * D * (m.rises - 1)) m.rise_bad++;
      end
      if (s_fd === 1'b1) begin
        m.fd_cnt++;
        m.fd_cycle = c;
      end
      if (s_busy !== ~s_rdy) m.busy_bad++;
      p_sclk = s_sclk;
      p_mosi = s_mosi;
      if (s_rdy === 1'b1) begin
        m.rdy_cycle = c;
        break;
      end
    end
  endtask

  task automatic check_frame(input string tag, input mon_t m, input logic [15:0] exp,
                             input int D, input int CS);
    chk({tag, ".word"},      int'(m.word), int'(exp));
    chk({tag, ".rises"},     m.rises, 16);
    chk({tag, ".rise_time"}, m.rise_bad, 0);
    chk({tag, ".cs_first"},  m.cs_first, 1);
    chk({tag, ".cs_last"},   m.cs_last, 32 * D);
    chk({tag, ".cs_low"},    m.cs_low, 32 * D);
    chk({tag, ".fd_cycle"},  m.fd_cycle, 32 * D + 1);
    chk({tag, ".fd_count"},  m.fd_cnt, 1);
    chk({tag, ".rdy_cycle"}, m.rdy_cycle, 32 * D + 1 + CS);
    chk({tag, ".mosi_hold"}, m.mosi_bad, 0);
    chk({tag, ".busy"},      m.busy_bad, 0);
    chk({tag, ".idle_pins"}, m.idle_bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[5];
    mon_t m, m1, m2;
    int   idle_err, fd_seen, sel, dly;
    logic [7:0] d, a;

    vt[0] = '{din: 8'hA5, after: 8'hA5, exp_word: 16'h3A50};
    vt[1] = '{din: 8'h3C, after: 8'hC3, exp_word: 16'h33C0};
    vt[2] = '{din: 8'h00, after: 8'hFF, exp_word: 16'h3000};
    vt[3] = '{din: 8'hFF, after: 8'h00, exp_word: 16'h3FF0};
    vt[4] = '{din: 8'h81, after: 8'h7E, exp_word: 16'h3810};

    rst = 1'b1;
    din_a = 8'h00; valid_a = 1'b0;
    din_c = 8'h00; valid_c = 1'b0;

    // Reset values held while rst is high
    repeat (3) @(negedge clk);
    chk("rst.ready", rdy_a, 0);
    chk("rst.busy",  busy_a, 0);
    chk("rst.cs_n",  csn_a, 1);
    chk("rst.sclk",  sclk_a, 0);
    chk("rst.mosi",  mosi_a, 0);
    chk("rst.fd",    fd_a, 0);
    chk("rst.c_ready", rdy_c, 0);
    chk("rst.c_cs_n",  csn_c, 1);

    // Release: ready rises on the first edge afterwards
    rst = 1'b0;
    #1;
    chk("rel.ready_hold", rdy_a, 0);
    @(negedge clk);
    chk("rel.ready_first", rdy_a, 1);
    chk("rel.c_ready_first", rdy_c, 1);

    // Long idle with no valid
    idle_err = 0;
    repeat (500) begin
      @(negedge clk);
      if (csn_a !== 1'b1 || sclk_a !== 1'b0 || mosi_a !== 1'b0 || busy_a !== 1'b0 || rdy_a !== 1'b1)
        idle_err++;
    end
    chk("idle.pins", idle_err, 0);

    // Table-driven single frames; din is changed to 'after' right after accept
    for (int i = 0; i < 5; i++) begin
      launch(1'b0, vt[i].din, $sformatf("vec%0d", i));
      monitor(1'b0, DA, vt[i].after, 1'b0, m);
      check_frame($sformatf("vec%0d", i), m, vt[i].exp_word, DA, CA);
    end

    // Back-to-back with valid held high: 00 then FF
    launch(1'b0, 8'h00, "b2b");
    monitor(1'b0, DA, 8'hFF, 1'b1, m1);
    monitor(1'b0, DA, 8'h00, 1'b0, m2);
    check_frame("b2b1", m1, 16'h3000, DA, CA);
    check_frame("b2b2", m2, 16'h3FF0, DA, CA);
    chk("b2b.gap_len", m1.rdy_cycle - m1.fd_cycle, CA);

    // Reset during bit 6 (cycle 78 is in its high half with CLK_DIV=4)
    launch(1'b0, 8'h5A, "rmf");
    @(negedge clk);
    drive(1'b0, 8'h5A, 1'b0);
    repeat (77) @(negedge clk);
    chk("rmf.pre_sclk", sclk_a, 1);
    chk("rmf.pre_cs_n", csn_a, 0);
    rst = 1'b1;
    #1;
    chk("rmf.cs_n",  csn_a, 1);
    chk("rmf.sclk",  sclk_a, 0);
    chk("rmf.mosi",  mosi_a, 0);
    chk("rmf.ready", rdy_a, 0);
    chk("rmf.busy",  busy_a, 0);
    fd_seen = (fd_a === 1'b1) ? 1 : 0;
    repeat (3) begin
      @(negedge clk);
      if (fd_a === 1'b1) fd_seen++;
    end
    rst = 1'b0;
    #1;
    chk("rmf.ready_hold", rdy_a, 0);
    @(negedge clk);
    chk("rmf.ready_first", rdy_a, 1);
    if (fd_a === 1'b1) fd_seen++;
    chk("rmf.no_fd", fd_seen, 0);
    launch(1'b0, 8'h81, "rmf_new");
    monitor(1'b0, DA, 8'h00, 1'b0, m);
    check_frame("rmf_new", m, 16'h3810, DA, CA);

    // Corner parameters: CLK_DIV=1, CS_HIGH=1, back-to-back 80 then 55
    launch(1'b1, 8'h80, "corner");
    monitor(1'b1, DC, 8'h55, 1'b1, m1);
    monitor(1'b1, DC, 8'h00, 1'b0, m2);
    check_frame("corner1", m1, 16'h3800, DC, CC);
    check_frame("corner2", m2, 16'h3550, DC, CC);

    // Randomized frames on either instance against the frame rule
    for (int i = 0; i < 12; i++) begin
      sel = int'($urandom_range(0, 1));
      d   = 8'($urandom);
      a   = 8'($urandom);
      dly = int'($urandom_range(0, 4));
      repeat (dly) @(negedge clk);
      launch(sel != 0, d, $sformatf("rnd%0d", i));
      monitor(sel != 0, (sel != 0) ? DC : DA, a, 1'b0, m);
      check_frame($sformatf("rnd%0d", i), m, model_word(d),
                  (sel != 0) ? DC : DA, (sel != 0) ? CC : CA);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
